vfp_axis_packer: RTL and testbench
==================================

VFP_AXIS_PACKER -- requirements
Module: vfp_axis_packer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 400, active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 300, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, ≥4.
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_valid  input  1  pixel strobe; no backpressure upstream.
REQ-007 SHALL have ports i_red, i_green, i_blue  input  8 each  pixel colour.
REQ-008 SHALL have ports i_x_coord, i_y_coord  input  16 each  pixel position.
REQ-009 SHALL have port m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-010 SHALL have port m_axis_tready  input  1  AXI4-Stream ready.
REQ-011 SHALL have port m_axis_tdata  output  24  {red, green, blue}.
REQ-012 SHALL have port m_axis_tuser  output  1  start of frame.
REQ-013 SHALL have port m_axis_tlast  output  1  end of line.
REQ-014 SHALL have port o_overflow  output  1  one-cycle pulse, pixel dropped on full FIFO.
REQ-015 SHALL have port o_coord_err  output  1  one-cycle pulse, out-of-range coordinate dropped.
REQ-016 SHALL have port o_frame_done  output  1  one-cycle pulse, last pixel of frame handshaken out.

Function
REQ-017 Beat accepted downstream only when m_axis_tvalid and m_axis_tready both high in one cycle.
REQ-018 tvalid, once high, SHALL stay high with tdata/tuser/tlast stable until accepted.
REQ-019 SOF flag = (x==0 and y==0); EOL flag = (x==IMG_WIDTH-1); both stored with pixel as 26-bit FIFO entry.
REQ-020 Pixel with x≥IMG_WIDTH or y≥IMG_HEIGHT SHALL be dropped and pulse o_coord_err the next cycle; FSM state unchanged.
REQ-021 FSM states: SYNC (reset state, drop all pixels until a SOF pixel), RUN (write every valid in-range pixel).
REQ-022 SYNC→RUN on valid SOF pixel, which is itself written to the FIFO.
REQ-023 RUN→SYNC on any write attempt while FIFO full (read not occurring that cycle); pixel dropped, o_overflow pulses next cycle.
REQ-024 Write and read in the same cycle while full SHALL succeed; occupancy unchanged; no overflow.
REQ-025 FIFO entries present at overflow SHALL still drain normally; FIFO never flushed except by reset.
REQ-026 Latency: pixel written into empty FIFO at edge N SHALL present tvalid after edge N+1; no combinational input-to-output path.
REQ-027 Write into empty FIFO concurrent with nothing to read SHALL not bypass; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 o_frame_done pulses the cycle after acceptance of the beat with EOL set and y==IMG_HEIGHT-1.
REQ-029 Downstream stall of any length SHALL lose no data unless FIFO fills (then REQ-023).

Reset
REQ-030 Reset asserted: tvalid, tuser, tlast, o_overflow, o_coord_err, o_frame_done = 0; tdata = 0; FIFO empty; FSM = SYNC.
REQ-031 Reset asserted mid-frame SHALL discard FIFO contents immediately; after release, output resumes only at next SOF pixel.

Structure
REQ-032 Package generic_pack SHALL hold the FIFO entry typedef (sof, eol, red, green, blue) and default IMG_WIDTH/IMG_HEIGHT/FIFO_DEPTH constants.
REQ-033 FIFO SHALL be a separate sub-module vfp_sync_fifo (single-clock, full/empty, registered output); FSM and flag logic in vfp_axis_packer.

Verification
REQ-034 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2), tready=1, contiguous valid -> 8 beats, tuser on beat 0 only, tlast on beats 3 and 7, o_frame_done once, one cycle after beat 7.
REQ-035 Pixels with y=1 before any SOF, then full frame -> pre-SOF pixels absent, first output beat has tuser=1, tdata = first SOF pixel.
REQ-036 FIFO_DEPTH=4, tready=0, 6 valid pixels -> 4 stored, o_overflow pulses on 5th, FSM SYNC, 6th dropped; tready=1 -> exactly 4 beats, then nothing until next SOF.
REQ-037 FIFO full, tready=1 and valid pixel same cycle -> no overflow, occupancy stays 4, order preserved.
REQ-038 Pixel x=IMG_WIDTH -> o_coord_err pulse, no beat; stream otherwise unaffected.
REQ-039 Reset asserted with 3 entries queued and tvalid high -> tvalid 0 immediately, no beats after release until SOF pixel.

Source files
------------

// File: rtl/generic_pack.sv
// Shared types and defaults for the video-to-AXI4-Stream packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default frame geometry and FIFO depth, the 26-bit FIFO entry
// (start-of-frame flag, end-of-line flag, 24-bit colour) and the FSM states.
package generic_pack;

    localparam int DEF_IMG_WIDTH  = 400;
    localparam int DEF_IMG_HEIGHT = 300;
    localparam int DEF_FIFO_DEPTH = 16;

    // One queued pixel; field order puts colour in the low 24 bits so the
    // colour slice maps straight onto tdata = {red, green, blue}.
    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pix_entry_t;

    localparam int PIX_ENTRY_W = $bits(pix_entry_t);

    // SYNC: discard input until a start-of-frame pixel shows up.
    // RUN:  queue every valid, in-range pixel.
    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } pack_state_t;

    // Frame geometry limits are compared against 16-bit coordinates.
    function automatic logic [15:0] coord_lim(input int v);
        return 16'(v);
    endfunction

endpackage

// File: rtl/vfp_axis_packer_if.sv
// AXI4-Stream video bus: 24-bit RGB beat with start-of-frame and end-of-line.
// Latency: n/a (wires only).
// Backpressure: beat transfers only when tvalid and tready are both high.
//
// Signals: tvalid/tdata/tuser/tlast driven by the master, tready by the slave.
interface vfp_axis_packer_if;

    logic        tvalid;
    logic        tready;
    logic [23:0] tdata;
    logic        tuser;
    logic        tlast;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/vfp_sync_fifo.sv
// Single-clock FIFO with a registered (first-word-fall-through) output stage.
// Latency: entry written at edge N is presented on rd_dat_o after edge N+1.
// Backpressure: full_o blocks writes unless a read completes in the same cycle.
//
// Ports: clk/rst (async, active-high); wr_vld_i/wr_dat_i write side;
// full_o; empty_o (nothing presented on the read side); rd_dat_o/rd_rdy_i
// read side. Capacity is DEPTH entries counting the output register.
module vfp_sync_fifo
    import generic_pack::*;
#(
    parameter int WIDTH = PIX_ENTRY_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rd_dat_o,
    input  logic             rd_rdy_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    mem_cnt_q;     // entries still in the RAM
    logic             out_vld_q;     // output register holds an entry
    logic [WIDTH-1:0] out_dat_q;

    logic rd_fire;
    logic wr_fire;
    logic load;

    // Occupancy counts the output register so "full" means DEPTH pixels
    // are waiting in total, not DEPTH in RAM plus one more on the bus.
    assign full_o   = (mem_cnt_q + CW'(out_vld_q)) == DEPTH_C;
    assign empty_o  = ~out_vld_q;
    assign rd_dat_o = out_dat_q;

    always_comb begin
        rd_fire = out_vld_q & rd_rdy_i;
        // A read in the same cycle frees a slot, so a full FIFO still
        // accepts the write and occupancy stays put.
        wr_fire = wr_vld_i & (~full_o | rd_fire);
        // Refill the output register only from entries already in RAM; a
        // same-cycle write is never bypassed straight to the output.
        load    = (mem_cnt_q != '0) & (~out_vld_q | rd_fire);
    end

    // RAM itself needs no reset: pointers and counters define validity.
    // When mem_cnt_q == DEPTH the FIFO is full with the output register
    // empty, so no write happens and the read/write slots never collide.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (load) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                out_dat_q <= mem_q[rd_ptr_q];
                out_vld_q <= 1'b1;
            end else if (rd_fire) begin
                out_vld_q <= 1'b0;
            end
            case ({wr_fire, load})
                2'b10:   mem_cnt_q <= mem_cnt_q + CW'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - CW'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vfp_axis_packer.sv
// Packs a free-running pixel strobe into an AXI4-Stream video bus with SOF/EOL.
// Latency: pixel written at edge N presents tvalid after edge N+1 (no bypass).
// Backpressure: none upstream; a full FIFO drops the pixel, pulses o_overflow, resyncs.
//
// Ports: clk, reset (async, active-high); i_valid, i_red/i_green/i_blue,
// i_x_coord/i_y_coord pixel input; m_axis (master) AXI4-Stream output with
// tuser = start of frame, tlast = end of line; o_overflow, o_coord_err and
// o_frame_done are one-cycle registered pulses.
module vfp_axis_packer
    import generic_pack::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [7:0]               i_red,
    input  logic [7:0]               i_green,
    input  logic [7:0]               i_blue,
    input  logic [15:0]              i_x_coord,
    input  logic [15:0]              i_y_coord,
    vfp_axis_packer_if.master        m_axis,
    output logic                     o_overflow,
    output logic                     o_coord_err,
    output logic                     o_frame_done
);

    localparam logic [15:0] X_LIM  = coord_lim(IMG_WIDTH);
    localparam logic [15:0] Y_LIM  = coord_lim(IMG_HEIGHT);
    localparam logic [15:0] X_LAST = coord_lim(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = coord_lim(IMG_HEIGHT - 1);

    pack_state_t state_q, state_d;
    logic        ovf_q, ovf_d;
    logic        cerr_q, cerr_d;
    logic        done_q, done_d;
    logic [15:0] line_q, line_d;
    logic [15:0] cur_line;

    logic        pix_in_range;
    logic        pix_sof;
    logic        pix_eol;
    logic        wr_try;
    logic        wr_vld;
    logic        rd_fire;
    logic        fifo_full;
    logic        fifo_empty;

    pix_entry_t             wr_ent;
    pix_entry_t             rd_ent;
    logic [PIX_ENTRY_W-1:0] rd_raw;

    // ------------------------------------------------------------------
    // Input classification
    // ------------------------------------------------------------------
    assign pix_in_range = (i_x_coord < X_LIM) && (i_y_coord < Y_LIM);
    assign pix_sof      = (i_x_coord == 16'd0) && (i_y_coord == 16'd0);
    assign pix_eol      = (i_x_coord == X_LAST);

    assign wr_ent = '{sof:   pix_sof,
                      eol:   pix_eol,
                      red:   i_red,
                      green: i_green,
                      blue:  i_blue};

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    vfp_sync_fifo #(
        .WIDTH (PIX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .wr_vld_i (wr_vld),
        .wr_dat_i (wr_ent),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .rd_dat_o (rd_raw),
        .rd_rdy_i (m_axis.tready)
    );

    assign rd_ent = rd_raw;

    // Output register is cleared by reset, so tdata/tuser/tlast read zero
    // while the FIFO is held in reset.
    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = {rd_ent.red, rd_ent.green, rd_ent.blue};
    assign m_axis.tuser  = rd_ent.sof;
    assign m_axis.tlast  = rd_ent.eol;

    assign rd_fire = m_axis.tvalid & m_axis.tready;

    // ------------------------------------------------------------------
    // Sync FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            ovf_q   <= 1'b0;
            cerr_q  <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            cerr_q  <= cerr_d;
            done_q  <= done_d;
            line_q  <= line_d;
        end
    end

    // ------------------------------------------------------------------
    // Sync FSM: next state and write control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wr_try  = 1'b0;
        wr_vld  = 1'b0;
        ovf_d   = 1'b0;
        cerr_d  = 1'b0;

        if (i_valid) begin
            if (!pix_in_range) begin
                // Out-of-range pixels never reach the FSM.
                cerr_d = 1'b1;
            end else begin
                case (state_q)
                    ST_SYNC: wr_try = pix_sof;
                    ST_RUN:  wr_try = 1'b1;
                    default: wr_try = 1'b0;
                endcase
            end
        end

        if (wr_try) begin
            if (fifo_full && !rd_fire) begin
                // The frame is now torn: drop it and wait for the next SOF.
                // Entries already queued still drain.
                ovf_d   = 1'b1;
                state_d = ST_SYNC;
            end else begin
                wr_vld  = 1'b1;
                state_d = ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-done tracking on the output side
    // ------------------------------------------------------------------
    // FIFO entries carry no y coordinate, so the output side counts lines
    // itself: a SOF beat restarts at line 0, each EOL beat advances it.
    always_comb begin
        line_d   = line_q;
        done_d   = 1'b0;
        cur_line = rd_ent.sof ? 16'd0 : line_q;

        if (rd_fire) begin
            if (rd_ent.eol) begin
                line_d = cur_line + 16'd1;
                done_d = (cur_line == Y_LAST);
            end else begin
                line_d = cur_line;
            end
        end
    end

    assign o_overflow   = ovf_q;
    assign o_coord_err  = cerr_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_vfp_axis_packer.sv
// Directed bench for vfp_axis_packer on a 4x2 frame with a 4-deep FIFO.
// Expected beats are queued as pixels are driven and popped as beats emerge.
module tb_vfp_axis_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_red, i_green, i_blue;
    logic [15:0] i_x_coord, i_y_coord;
    logic        o_overflow, o_coord_err, o_frame_done;

    vfp_axis_packer_if m_axis_if ();

    vfp_axis_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .i_valid      (i_valid),
        .i_red        (i_red),
        .i_green      (i_green),
        .i_blue       (i_blue),
        .i_x_coord    (i_x_coord),
        .i_y_coord    (i_y_coord),
        .m_axis       (m_axis_if),
        .o_overflow   (o_overflow),
        .o_coord_err  (o_coord_err),
        .o_frame_done (o_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int seq = 0;
    int beats = 0;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    int ovf_cnt = 0, ovf_cyc = -1;
    int cerr_cnt = 0, cerr_cyc = -1;
    int done_cnt = 0, done_cyc = -1;
    bit prev_stall = 1'b0;
    logic [25:0] prev_obs = '0;
    logic [25:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then cross the rising edge.
    task automatic cyc();
        logic [25:0] obs;
        logic [25:0] exp_ent;
        @(negedge clk);
        obs = {m_axis_if.tuser, m_axis_if.tlast, m_axis_if.tdata};
        if (prev_stall) begin
            chk("hold_valid", 32'(m_axis_if.tvalid), 32'd1);
            chk("hold_data", 32'(obs), 32'(prev_obs));
        end
        prev_stall = m_axis_if.tvalid && !m_axis_if.tready;
        prev_obs   = obs;
        if (m_axis_if.tready) begin
            if (sb.size() == 0) begin
                chk("no_beat", 32'(m_axis_if.tvalid), 32'd0);
            end else if (m_axis_if.tvalid) begin
                exp_ent = sb.pop_front();
                chk("beat", 32'(obs), 32'(exp_ent));
                beats++;
                last_beat_cyc = cyc_n;
                if (first_beat_cyc < 0) first_beat_cyc = cyc_n;
            end
        end
        if (o_overflow)   begin ovf_cnt++;  ovf_cyc  = cyc_n; end
        if (o_coord_err)  begin cerr_cnt++; cerr_cyc = cyc_n; end
        if (o_frame_done) begin done_cnt++; done_cyc = cyc_n; end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic pix(input int x, input int y, input bit keep);
        logic [7:0] r, g, b;
        logic       sof, eol;
        r = 8'(x * 37 + y * 11 + seq);
        g = 8'($urandom);
        b = 8'(seq);
        seq++;
        sof = (x == 0) && (y == 0);
        eol = (x == W - 1);
        i_valid   = 1'b1;
        i_x_coord = 16'(x);
        i_y_coord = 16'(y);
        i_red     = r;
        i_green   = g;
        i_blue    = b;
        if (keep) sb.push_back({sof, eol, r, g, b});
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic frame(input bit keep);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix(x, y, keep);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
        chk(tag, 32'(sb.size()), 32'd0);
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        prev_stall = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        int k;
        int b0;
        int ovf0;
        rst = 1'b1;
        i_valid = 1'b0;
        i_red = '0; i_green = '0; i_blue = '0;
        i_x_coord = '0; i_y_coord = '0;
        m_axis_if.tready = 1'b0;
        repeat (2) cyc();

        // Reset state
        chk("rst_tvalid", 32'(m_axis_if.tvalid), 32'd0);
        chk("rst_tuser",  32'(m_axis_if.tuser),  32'd0);
        chk("rst_tlast",  32'(m_axis_if.tlast),  32'd0);
        chk("rst_tdata",  32'(m_axis_if.tdata),  32'd0);
        chk("rst_pulses", 32'({o_overflow, o_coord_err, o_frame_done}), 32'd0);
        rst = 1'b0;
        cyc();

        // Full frame, tready high, contiguous pixels
        m_axis_if.tready = 1'b1;
        k = cyc_n;
        b0 = beats;
        frame(1'b1);
        drain("t1_drain", 40);
        chk("t1_latency", 32'(first_beat_cyc), 32'(k + 2));
        chk("t1_beats", 32'(beats - b0), 32'd8);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_done_cyc", 32'(done_cyc), 32'(last_beat_cyc + 1));

        // Pre-SOF pixels after reset are discarded
        do_reset();
        pix(0, 1, 1'b0);
        pix(1, 1, 1'b0);
        pix(2, 1, 1'b0);
        frame(1'b1);
        drain("t2_drain", 40);
        chk("t2_done_cnt", 32'(done_cnt), 32'd2);

        // Overflow with a stalled sink
        m_axis_if.tready = 1'b0;
        b0 = beats;
        pix(0, 0, 1'b1);
        pix(1, 0, 1'b1);
        pix(2, 0, 1'b1);
        pix(3, 0, 1'b1);
        k = cyc_n;
        pix(0, 1, 1'b0);
        pix(1, 1, 1'b0);
        repeat (2) cyc();
        chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("t3_ovf_cyc", 32'(ovf_cyc), 32'(k + 1));
        chk("t3_stall_valid", 32'(m_axis_if.tvalid), 32'd1);
        m_axis_if.tready = 1'b1;
        pix(2, 1, 1'b0);
        pix(3, 1, 1'b0);
        drain("t3_drain", 40);
        chk("t3_beats", 32'(beats - b0), 32'd4);
        chk("t3_ovf_after", 32'(ovf_cnt), 32'd1);
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);

        // Write and read together while full
        m_axis_if.tready = 1'b0;
        pix(0, 0, 1'b1);
        pix(1, 0, 1'b1);
        pix(2, 0, 1'b1);
        pix(3, 0, 1'b1);
        cyc();
        ovf0 = ovf_cnt;
        m_axis_if.tready = 1'b1;
        pix(0, 1, 1'b1);
        m_axis_if.tready = 1'b0;
        cyc();
        chk("t4_no_ovf", 32'(ovf_cnt), 32'(ovf0));
        // Occupancy still four: the next write must overflow
        pix(1, 1, 1'b0);
        cyc();
        chk("t4_ovf_full", 32'(ovf_cnt), 32'(ovf0 + 1));
        m_axis_if.tready = 1'b1;
        drain("t4_drain", 40);

        // Out-of-range coordinates
        ovf0 = ovf_cnt;
        pix(0, 0, 1'b1);
        pix(1, 0, 1'b1);
        k = cyc_n;
        pix(W, 0, 1'b0);
        pix(2, 0, 1'b1);
        chk("t5_cerr_cyc", 32'(cerr_cyc), 32'(k + 1));
        pix(3, 0, 1'b1);
        pix(0, H, 1'b0);
        for (int x = 0; x < W; x++) pix(x, 1, 1'b1);
        drain("t5_drain", 40);
        chk("t5_cerr_cnt", 32'(cerr_cnt), 32'd2);
        chk("t5_ovf", 32'(ovf_cnt), 32'(ovf0));
        chk("t5_done_cnt", 32'(done_cnt), 32'd3);

        // Reset mid-frame with entries queued
        m_axis_if.tready = 1'b0;
        pix(0, 0, 1'b0);
        pix(1, 0, 1'b0);
        pix(2, 0, 1'b0);
        cyc();
        chk("t6_pre_valid", 32'(m_axis_if.tvalid), 32'd1);
        rst = 1'b1;
        prev_stall = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_axis_if.tvalid), 32'd0);
        chk("t6_rst_tdata", 32'(m_axis_if.tdata), 32'd0);
        cyc();
        rst = 1'b0;
        m_axis_if.tready = 1'b1;
        pix(3, 0, 1'b0);
        for (int x = 0; x < W; x++) pix(x, 1, 1'b0);
        repeat (4) cyc();
        b0 = beats;
        frame(1'b1);
        drain("t6_drain", 40);
        chk("t6_beats", 32'(beats - b0), 32'd8);
        chk("t6_done_cnt", 32'(done_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
